// File: rtl/t07_spi_rx_buffer_if.sv
// Bundles the MMIO fetch/read signals and the quad-SPI receiver word handshake.
interface t07_spi_rx_buffer_if #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic             start_i;
    logic [7:0]       len_i;
    logic [WIDTH-1:0] spi_data_i;
    logic             spi_ack_i;
    logic             spi_enable_o;
    logic             rd_en_i;
    logic [WIDTH-1:0] rd_data_o;
    logic             rd_valid_o;
    logic             full_o;
    logic [CW-1:0]    count_o;
    logic             busy_o;
    logic             done_o;
    logic             overflow_o;

    // Driver side: MMIO command/read port plus the SPI receiver.
    modport master (
        output start_i, len_i, spi_data_i, spi_ack_i, rd_en_i,
        input  spi_enable_o, rd_data_o, rd_valid_o, full_o, count_o,
               busy_o, done_o, overflow_o
    );

    // Buffer side.
    modport slave (
        input  start_i, len_i, spi_data_i, spi_ack_i, rd_en_i,
        output spi_enable_o, rd_data_o, rd_valid_o, full_o, count_o,
               busy_o, done_o, overflow_o
    );
endinterface

// File: rtl/t07_spi_rx_buffer.sv
// Receive buffer and fetch controller: captures SPI words into a show-ahead
// FIFO, throttles the link when the FIFO fills, and flags dropped words.
module t07_spi_rx_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    t07_spi_rx_buffer_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH      = 2'd1,
        WAIT_SPACE = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t           state;
    logic [7:0]       remaining;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             spi_enable;
    logic             busy;
    logic             done;
    logic             overflow;

    logic             full_c;
    logic             empty_c;
    logic             push_c;
    logic             pop_c;
    logic             drop_c;
    logic [CW-1:0]    count_next_c;

    // Handshake qualification and next occupancy.
    always_comb begin
        full_c       = (count == CW'(DEPTH));
        empty_c      = (count == CW'(0));
        push_c       = (state == FETCH) && bus.spi_ack_i && !full_c;
        pop_c        = bus.rd_en_i && !empty_c;
        drop_c       = bus.spi_ack_i &&
                       ((state == WAIT_SPACE) || ((state == FETCH) && full_c));
        count_next_c = count;
        if (push_c && !pop_c) begin
            count_next_c = count + CW'(1);
        end else if (pop_c && !push_c) begin
            count_next_c = count - CW'(1);
        end
    end

    // FIFO storage, wrapping pointers and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) begin
                mem[wr_ptr] <= bus.spi_data_i;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_next_c;
        end
    end

    // Fetch sequencer with registered enable/busy/done/overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            remaining  <= '0;
            spi_enable <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start_i) begin
                        overflow <= 1'b0;
                        if (bus.len_i != 8'd0) begin
                            remaining  <= bus.len_i;
                            state      <= FETCH;
                            spi_enable <= 1'b1;
                            busy       <= 1'b1;
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (drop_c) begin
                        overflow <= 1'b1;
                    end
                    if (push_c) begin
                        remaining <= remaining - 8'(remaining != 8'd0);
                        if (remaining == 8'd1) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            busy       <= 1'b0;
                            spi_enable <= 1'b0;
                        end else if (count_next_c == CW'(DEPTH)) begin
                            state      <= WAIT_SPACE;
                            spi_enable <= 1'b0;
                        end
                    end
                end
                WAIT_SPACE: begin
                    if (drop_c) begin
                        overflow <= 1'b1;
                    end
                    // Space was freed by a pop on the previous edge.
                    if (!full_c) begin
                        state      <= FETCH;
                        spi_enable <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs; read-side status is decoded straight from the FIFO registers.
    assign bus.spi_enable_o = spi_enable;
    assign bus.busy_o       = busy;
    assign bus.done_o       = done;
    assign bus.overflow_o   = overflow;
    assign bus.rd_data_o    = mem[rd_ptr];
    assign bus.rd_valid_o   = !empty_c;
    assign bus.full_o       = full_c;
    assign bus.count_o      = count;
endmodule

// File: tb/tb_t07_spi_rx_buffer.sv
// Directed bench for t07_spi_rx_buffer (DEPTH=4, WIDTH=32).
module tb_t07_spi_rx_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   done_cnt;

    t07_spi_rx_buffer_if #(.DEPTH(4), .WIDTH(32)) bus ();

    t07_spi_rx_buffer #(.DEPTH(4), .WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs set afterwards are sampled at the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks          = 0;
        failures        = 0;
        done_cnt        = 0;
        rst             = 1'b1;
        bus.start_i     = 1'b0;
        bus.len_i       = 8'd0;
        bus.spi_data_i  = 32'd0;
        bus.spi_ack_i   = 1'b0;
        bus.rd_en_i     = 1'b0;
        cyc();
        cyc();

        // Reset state
        chk("rst_enable",   64'(bus.spi_enable_o), 64'(0));
        chk("rst_busy",     64'(bus.busy_o),       64'(0));
        chk("rst_done",     64'(bus.done_o),       64'(0));
        chk("rst_overflow", 64'(bus.overflow_o),   64'(0));
        chk("rst_valid",    64'(bus.rd_valid_o),   64'(0));
        chk("rst_full",     64'(bus.full_o),       64'(0));
        chk("rst_count",    64'(bus.count_o),      64'(0));
        chk("rst_data",     64'(bus.rd_data_o),    64'(0));
        rst = 1'b0;
        cyc();

        // len=3, acks 9 cycles apart, no pops
        bus.start_i = 1'b1; bus.len_i = 8'd3;
        cyc();
        bus.start_i = 1'b0;
        chk("l3_busy",   64'(bus.busy_o),       64'(1));
        chk("l3_enable", 64'(bus.spi_enable_o), 64'(1));
        chk("l3_valid0", 64'(bus.rd_valid_o),   64'(0));
        for (int i = 1; i <= 3; i++) begin
            for (int j = 0; j < 8; j++) cyc();
            bus.spi_data_i = 32'h1111_1111 * 32'(i);
            bus.spi_ack_i  = 1'b1;
            cyc();
            bus.spi_ack_i  = 1'b0;
            if (bus.done_o) done_cnt++;
            chk("l3_count", 64'(bus.count_o), 64'(i));
        end
        chk("l3_done",     64'(bus.done_o),       64'(1));
        chk("l3_busy_end", 64'(bus.busy_o),       64'(0));
        chk("l3_en_end",   64'(bus.spi_enable_o), 64'(0));
        chk("l3_head",     64'(bus.rd_data_o),    64'(32'h1111_1111));
        chk("l3_ovf",      64'(bus.overflow_o),   64'(0));
        cyc();
        if (bus.done_o) done_cnt++;
        chk("l3_done_once", 64'(done_cnt), 64'(1));

        // Ack in IDLE is ignored
        bus.spi_data_i = 32'hDEAD_BEEF; bus.spi_ack_i = 1'b1;
        cyc();
        bus.spi_ack_i = 1'b0;
        chk("idle_ack_count", 64'(bus.count_o),    64'(3));
        chk("idle_ack_ovf",   64'(bus.overflow_o), 64'(0));

        // Drain in order, then pop while empty
        for (int i = 1; i <= 3; i++) begin
            chk("l3_pop_data", 64'(bus.rd_data_o), 64'(32'h1111_1111 * 32'(i)));
            bus.rd_en_i = 1'b1;
            cyc();
            bus.rd_en_i = 1'b0;
            chk("l3_pop_count", 64'(bus.count_o), 64'(3 - i));
        end
        chk("drain_valid", 64'(bus.rd_valid_o), 64'(0));
        bus.rd_en_i = 1'b1;
        cyc();
        bus.rd_en_i = 1'b0;
        chk("empty_pop_count", 64'(bus.count_o), 64'(0));

        // len=6: fill, backpressure, overflow, resume
        bus.start_i = 1'b1; bus.len_i = 8'd6;
        cyc();
        bus.start_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.spi_data_i = 32'hA0 + 32'(i);
            bus.spi_ack_i  = 1'b1;
            cyc();
        end
        bus.spi_ack_i = 1'b0;
        chk("fill_full",   64'(bus.full_o),       64'(1));
        chk("fill_count",  64'(bus.count_o),      64'(4));
        chk("fill_enable", 64'(bus.spi_enable_o), 64'(0));
        chk("fill_busy",   64'(bus.busy_o),       64'(1));
        chk("fill_ovf0",   64'(bus.overflow_o),   64'(0));
        bus.spi_data_i = 32'h0000_0BAD; bus.spi_ack_i = 1'b1;
        cyc();
        bus.spi_ack_i = 1'b0;
        chk("drop_ovf",   64'(bus.overflow_o), 64'(1));
        chk("drop_count", 64'(bus.count_o),    64'(4));
        chk("drop_head",  64'(bus.rd_data_o),  64'(32'hA0));
        bus.rd_en_i = 1'b1;
        cyc();
        bus.rd_en_i = 1'b0;
        chk("ws_pop_count", 64'(bus.count_o),      64'(3));
        chk("ws_pop_head",  64'(bus.rd_data_o),    64'(32'hA1));
        chk("ws_pop_en",    64'(bus.spi_enable_o), 64'(0));
        cyc();
        chk("ws_resume_en", 64'(bus.spi_enable_o), 64'(1));
        bus.spi_data_i = 32'hA4; bus.spi_ack_i = 1'b1; bus.rd_en_i = 1'b1;
        cyc();
        bus.rd_en_i = 1'b0;
        chk("resume_count", 64'(bus.count_o),      64'(3));
        chk("resume_en",    64'(bus.spi_enable_o), 64'(1));
        bus.spi_data_i = 32'hA5;
        cyc();
        bus.spi_ack_i = 1'b0;
        chk("l6_done",  64'(bus.done_o),       64'(1));
        chk("l6_en",    64'(bus.spi_enable_o), 64'(0));
        chk("l6_count", 64'(bus.count_o),      64'(4));
        chk("l6_ovf",   64'(bus.overflow_o),   64'(1));
        for (int i = 2; i <= 5; i++) begin
            chk("l6_order", 64'(bus.rd_data_o), 64'(32'hA0 + 32'(i)));
            bus.rd_en_i = 1'b1;
            cyc();
            bus.rd_en_i = 1'b0;
        end
        chk("l6_empty", 64'(bus.count_o), 64'(0));

        // Simultaneous push/pop, non-empty then empty
        bus.start_i = 1'b1; bus.len_i = 8'd2;
        cyc();
        bus.start_i = 1'b0;
        chk("start_clears_ovf", 64'(bus.overflow_o), 64'(0));
        bus.spi_data_i = 32'hC0; bus.spi_ack_i = 1'b1;
        cyc();
        chk("pp_count1", 64'(bus.count_o), 64'(1));
        bus.spi_data_i = 32'hC1; bus.rd_en_i = 1'b1;
        cyc();
        bus.spi_ack_i = 1'b0; bus.rd_en_i = 1'b0;
        chk("pp_count_same", 64'(bus.count_o),   64'(1));
        chk("pp_head_new",   64'(bus.rd_data_o), 64'(32'hC1));
        chk("pp_done",       64'(bus.done_o),    64'(1));
        bus.rd_en_i = 1'b1;
        cyc();
        bus.rd_en_i = 1'b0;
        bus.start_i = 1'b1; bus.len_i = 8'd1;
        cyc();
        bus.start_i = 1'b0;
        bus.spi_data_i = 32'hC2; bus.spi_ack_i = 1'b1; bus.rd_en_i = 1'b1;
        cyc();
        bus.spi_ack_i = 1'b0; bus.rd_en_i = 1'b0;
        chk("pp_empty_count", 64'(bus.count_o),   64'(1));
        chk("pp_empty_head",  64'(bus.rd_data_o), 64'(32'hC2));
        bus.rd_en_i = 1'b1;
        cyc();
        bus.rd_en_i = 1'b0;

        // Pointer wrap: len=10, pop two cycles after each ack
        done_cnt = 0;
        bus.start_i = 1'b1; bus.len_i = 8'd10;
        cyc();
        bus.start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.spi_data_i = 32'h100 + 32'(i); bus.spi_ack_i = 1'b1;
            cyc();
            bus.spi_ack_i = 1'b0;
            if (bus.done_o) done_cnt++;
            cyc();
            if (bus.done_o) done_cnt++;
            chk("wrap_data", 64'(bus.rd_data_o), 64'(32'h100 + 32'(i)));
            chk("wrap_full", 64'(bus.full_o),    64'(0));
            bus.rd_en_i = 1'b1;
            cyc();
            bus.rd_en_i = 1'b0;
            if (bus.done_o) done_cnt++;
        end
        chk("wrap_done_once", 64'(done_cnt),       64'(1));
        chk("wrap_empty",     64'(bus.count_o),    64'(0));
        chk("wrap_ovf",       64'(bus.overflow_o), 64'(0));

        // len=0 completes immediately without enabling the link
        bus.start_i = 1'b1; bus.len_i = 8'd0;
        cyc();
        bus.start_i = 1'b0;
        chk("l0_done", 64'(bus.done_o),       64'(1));
        chk("l0_en",   64'(bus.spi_enable_o), 64'(0));
        chk("l0_busy", 64'(bus.busy_o),       64'(0));
        cyc();
        chk("l0_done_clr", 64'(bus.done_o),       64'(0));
        chk("l0_en2",      64'(bus.spi_enable_o), 64'(0));

        // len=5 with a start issued mid-fetch that must be ignored
        bus.start_i = 1'b1; bus.len_i = 8'd5;
        cyc();
        bus.start_i = 1'b0;
        bus.spi_data_i = 32'hD0; bus.spi_ack_i = 1'b1;
        cyc();
        bus.spi_ack_i = 1'b0;
        bus.start_i = 1'b1; bus.len_i = 8'd1;
        cyc();
        bus.start_i = 1'b0;
        chk("busy_start_busy", 64'(bus.busy_o), 64'(1));
        for (int i = 1; i <= 4; i++) begin
            bus.spi_data_i = 32'hD0 + 32'(i); bus.spi_ack_i = 1'b1; bus.rd_en_i = 1'b1;
            cyc();
            bus.spi_ack_i = 1'b0; bus.rd_en_i = 1'b0;
            chk("l5_done", 64'(bus.done_o),  64'(i == 4));
            chk("l5_busy", 64'(bus.busy_o),  64'(i != 4));
        end
        chk("l5_count", 64'(bus.count_o),   64'(1));
        chk("l5_head",  64'(bus.rd_data_o), 64'(32'hD4));
        bus.rd_en_i = 1'b1;
        cyc();
        bus.rd_en_i = 1'b0;

        // Reset mid-fetch with two words held
        bus.start_i = 1'b1; bus.len_i = 8'd5;
        cyc();
        bus.start_i = 1'b0;
        bus.spi_data_i = 32'hE0; bus.spi_ack_i = 1'b1;
        cyc();
        bus.spi_data_i = 32'hE1;
        cyc();
        bus.spi_ack_i = 1'b0;
        chk("mid_count", 64'(bus.count_o),      64'(2));
        chk("mid_en",    64'(bus.spi_enable_o), 64'(1));
        rst = 1'b1;
        #1;
        chk("mrst_en",    64'(bus.spi_enable_o), 64'(0));
        chk("mrst_busy",  64'(bus.busy_o),       64'(0));
        chk("mrst_count", 64'(bus.count_o),      64'(0));
        chk("mrst_valid", 64'(bus.rd_valid_o),   64'(0));
        chk("mrst_data",  64'(bus.rd_data_o),    64'(0));
        chk("mrst_full",  64'(bus.full_o),       64'(0));
        #1;
        rst = 1'b0;
        bus.spi_data_i = 32'hE2; bus.spi_ack_i = 1'b1;
        cyc();
        bus.spi_ack_i = 1'b0;
        chk("post_rst_count", 64'(bus.count_o),      64'(0));
        chk("post_rst_en",    64'(bus.spi_enable_o), 64'(0));
        chk("post_rst_ovf",   64'(bus.overflow_o),   64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/t07_spi_rx_buffer.md
# t07_spi_rx_buffer

Receive-side buffer and fetch controller between the t07 quad-SPI receiver and the MMIO bus. On an MMIO start command it enables the ESP32 link, captures each assembled 32-bit word on the receiver's ack pulse, stores it in a small FIFO, and presents it to MMIO with show-ahead read semantics. When the FIFO fills, it applies backpressure by dropping the SPI enable. It flags any word lost to overflow.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of two, ≥2
- WIDTH, 32: word width; equals the receiver's assembled word width

Ports:
- clk  input  1  system clock; same clock as the quad-SPI receiver
- rst  input  1  reset, asynchronous, active-high
- start_i  input  1  one-cycle fetch command from MMIO
- len_i  input  8  number of words to fetch; sampled with start_i
- spi_data_i  input  WIDTH  assembled word from receiver; valid when spi_ack_i=1
- spi_ack_i  input  1  receiver word-complete pulse
- spi_enable_o  output  1  enable to receiver/ESP32
- rd_en_i  input  1  MMIO pop request
- rd_data_o  output  WIDTH  FIFO head word (show-ahead)
- rd_valid_o  output  1  FIFO non-empty
- full_o  output  1  FIFO holds DEPTH words
- count_o  output  $clog2(DEPTH)+1  words held
- busy_o  output  1  state is FETCH or WAIT_SPACE
- done_o  output  1  one-cycle pulse when the fetch completes
- overflow_o  output  1  sticky; a word was dropped

## Operation
- States: IDLE, FETCH, WAIT_SPACE, DONE. State and all outputs are registered except rd_data_o, rd_valid_o, full_o and count_o, which are decoded from FIFO registers.
- Remaining counter (8 bits):
  - Loads len_i on start_i in IDLE.
  - Decrements on each accepted push.
  - Never wraps.
- State transitions:
  - IDLE: on start_i with len_i≠0, load remaining, clear overflow_o, and go to FETCH. On start_i with len_i=0, clear overflow_o and go to DONE.
  - FETCH: spi_enable_o=1.
    - An accepted ack with remaining=1 goes to DONE.
    - Otherwise, if the push leaves the FIFO full (count=DEPTH after the update), go to WAIT_SPACE.
  - WAIT_SPACE: spi_enable_o=0. Return to FETCH in the cycle after count<DEPTH.
  - DONE: done_o=1 for one cycle, then return to IDLE.
- start_i is ignored outside IDLE.
- Push rules:
  - A push happens only in FETCH, on spi_ack_i with FIFO not full.
  - An ack in WAIT_SPACE, or an ack in FETCH with FIFO full, drops the word and sets overflow_o. The remaining counter does not change.
  - An ack in IDLE or DONE is ignored; overflow_o does not change.
- Pop rules:
  - rd_en_i with rd_valid_o=1 advances the head.
  - rd_en_i when empty is ignored.
  - Simultaneous push and pop on a non-empty FIFO leaves count unchanged and accepts both.
  - Simultaneous push and pop on an empty FIFO performs only the push.
- FIFO uses read and write pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus a count register.
- overflow_o stays set until the next accepted start_i or reset.
- Reset (any time, including mid-fetch):
  - state→IDLE; remaining, pointers and count→0.
  - spi_enable_o=0, done_o=0, busy_o=0, overflow_o=0, rd_valid_o=0, full_o=0, count_o=0, rd_data_o=0.
  - FIFO storage cleared.

## Timing
- start_i sampled at edge N: busy_o=1 and spi_enable_o=1 from edge N.
- Accepted ack at edge k:
  - count_o, rd_valid_o and rd_data_o (if previously empty) update after edge k.
  - Push-to-read latency is 1 cycle.
- The final accepted ack at edge k produces done_o=1 for cycle k→k+1, with busy_o=0 and spi_enable_o=0 from edge k.
- Entering WAIT_SPACE at edge k drops spi_enable_o from edge k.
- Pop at edge p that frees space in WAIT_SPACE: FETCH from edge p+1, spi_enable_o=1 from edge p+1.
- Pop at edge p: rd_data_o shows the next entry after edge p.
- len_i=0: done_o pulses in the cycle after start_i; spi_enable_o never asserts.

## Test plan
- Reset mid-fetch (FIFO holding 2 words, spi_enable_o=1) → all outputs 0 in the same cycle, state IDLE, subsequent acks ignored.
- start_i with len_i=3, acks with 0x11111111, 0x22222222, 0x33333333 spaced 9 cycles apart, no pops → count_o=3, rd_data_o=0x11111111, done_o pulses once after the third ack, spi_enable_o=0, overflow_o=0.
- len_i=6, DEPTH=4, no pops → enable drops after the 4th push, full_o=1. A 5th ack sets overflow_o and count stays 4. Pop 1 word → enable returns the next cycle, and the fetch finishes after 2 more accepted acks.
- FIFO holding 1 word, push and pop in the same cycle → count_o stays 1, rd_data_o=new word. FIFO empty, push and pop → count_o=1.
- Pointer wrap: len_i=10, pop each word 2 cycles after its ack → words read in order 0..9, never full, done_o once.
- len_i=0 → done_o one cycle later, spi_enable_o stays 0, a start_i issued while busy during a separate len_i=5 fetch is ignored.
